fft_butterfly_pipe: RTL and testbench
=====================================

// Module: fft_butterfly_pipe
// PURPOSE
//  Pipelined radix-2 DIT butterfly for the FFT datapath: X = a + w*b, Y = a - w*b on complex
//  signed fixed-point samples. Sits directly downstream of the fixed-point `multiplier`:
//  instantiates four of them for the complex twiddle product, registers the products and
//  feeds the add/subtract stage. Valid/ready on both sides; bubbles collapse; last tag passes through.
// PARAMETERS
//  N      16  sample/twiddle word width (two's complement), per real/imag part
//  Q       8  fractional bits (Q(N-Q).Q); 1.0 = 1<<Q
//  SCALE   0  1: outputs are (sum)>>>1 computed at N+1 bits (no growth); 0: N-bit wrap
// PORTS
//  clk        in   1  clock, all state on rising edge
//  rst        in   1  synchronous, active-high reset
//  in_valid   in   1  input beat valid
//  in_ready   out  1  stage 1 can accept; beat transfers when in_valid & in_ready
//  in_last    in   1  frame tag, carried unchanged to out_last
//  a_re,a_im  in   N  butterfly upper input
//  b_re,b_im  in   N  butterfly lower input
//  w_re,w_im  in   N  twiddle factor
//  out_valid  out  1  output beat valid
//  out_ready  in   1  downstream accepts; beat transfers when out_valid & out_ready
//  out_last   out  1  tag of the current output beat
//  x_re,x_im  out  N  a + w*b
//  y_re,y_im  out  N  a - w*b
// BEHAVIOUR
//  - Reset: v1,v2,v3 = 0; in_ready = 1; out_valid = 0; all data/tag regs (so x*,y*,out_last) = 0.
//    Reset mid-operation discards every in-flight beat; no partial output emerges.
//  - Three register stages, each with a valid bit vk. Stage k loads when ~vk | ld(k+1);
//    ld4 = out_ready. in_ready = ~v1 | ld2. Stage k clears vk when it passes data on and loads nothing.
//  - Latency 3 cycles from accepted input to out_valid with no stall; throughput 1 beat/cycle.
//  - S1: register a, b, w, last.
//  - S2: products p_rr=b_re*w_re, p_ii=b_im*w_im, p_ri=b_re*w_im, p_ir=b_im*w_re via `multiplier`
//    semantics: exact signed 2N-bit product, bits [N-1+Q:Q] kept (= floor(A*B/2^Q), wrapped to N).
//    Register t_re = p_rr - p_ii, t_im = p_ri + p_ir (N-bit wrap), plus a, last.
//  - S3: SCALE=0: x = a + t, y = a - t, N-bit wrap, no saturation.
//    SCALE=1: sum/difference sign-extended to N+1 bits, arithmetic shift right 1, low N bits kept
//    (floor rounding).
//  - Outputs x*,y*,out_last are the S3 registers; stable while out_valid & ~out_ready.
//  - Simultaneous in-accept and out-accept with all stages full: all stages shift, no beat lost.
//  - Inputs sampled only on transfer; in_* ignored when ~in_ready. No beat reordering/duplication.
//  - Most-negative operand (-2^(N-1)) multiplies exactly (magnitude held as unsigned N bits).
// TESTING (N=16, Q=8, out_ready=1 unless stated)
//  1 a=(0x0100,0) b=(0x0080,0) w=(0x0100,0) -> after 3 cycles x=(0x0180,0), y=(0x0080,0).
//  2 a=0 b=(0x0080,0x0080) w=(0,0xFF00) (-j) -> x=(0x0080,0xFF80), y=(0xFF80,0x0080).
//  3 Floor rounding: b=(0x0001,0) w=(0x0080,0) a=0 -> x_re=0x0000; b_re=0xFFFF -> x_re=0xFFFF.
//  4 Overflow: a_re=0x7F00, w*b re=0x0200: SCALE=0 -> x_re=0x8100 (wrap); SCALE=1 -> x_re=0x4080.
//  5 Backpressure: out_ready=0, stream 5 beats (last on 5th) -> in_ready low after 3 accepted;
//    out_ready=1 -> all 5 emerge in order, out_last only on 5th, outputs held while stalled.
//  6 rst asserted 1 cycle with 3 beats in flight -> next cycle out_valid=0, in_ready=1,
//    outputs 0; no stale beat ever appears afterwards.

Source files
------------

// File: rtl/fft_butterfly_pipe.sv
// Pipelined radix-2 DIT butterfly: x = a + w*b, y = a - w*b, complex fixed point.
// Ports: clk/rst, in_valid/in_ready/in_last + a,b,w in; out_valid/out_ready/out_last + x,y out.

module multiplier #(
  parameter int N = 16,
  parameter int Q = 8
) (
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  output logic [N-1:0] p
);
  logic [N-1:0]   mag_a;
  logic [N-1:0]   mag_b;
  logic [2*N-1:0] mag_p;
  logic [2*N-1:0] prod;
  logic           neg;
  logic           unused_bits;

  // Magnitudes as unsigned N bits so -2^(N-1) is exact.
  always_comb begin
    mag_a = a[N-1] ? -a : a;
    mag_b = b[N-1] ? -b : b;
    mag_p = {{N{1'b0}}, mag_a} * {{N{1'b0}}, mag_b};
    neg   = a[N-1] ^ b[N-1];
    prod  = neg ? -mag_p : mag_p;
  end

  // Bit select of the two's complement product floors.
  assign p = prod[N-1+Q:Q];
  assign unused_bits = ^{prod[2*N-1:N+Q], prod[Q-1:0]};
endmodule

module fft_butterfly_pipe #(
  parameter int N     = 16,
  parameter int Q     = 8,
  parameter int SCALE = 0
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic         in_last,
  input  logic [N-1:0] a_re,
  input  logic [N-1:0] a_im,
  input  logic [N-1:0] b_re,
  input  logic [N-1:0] b_im,
  input  logic [N-1:0] w_re,
  input  logic [N-1:0] w_im,
  output logic         out_valid,
  input  logic         out_ready,
  output logic         out_last,
  output logic [N-1:0] x_re,
  output logic [N-1:0] x_im,
  output logic [N-1:0] y_re,
  output logic [N-1:0] y_im
);
  typedef struct packed {
    logic [N-1:0] re;
    logic [N-1:0] im;
  } cplx_t;

  typedef struct packed {
    cplx_t a;
    cplx_t b;
    cplx_t w;
    logic  last;
  } s1_t;

  typedef struct packed {
    cplx_t a;
    cplx_t t;
    logic  last;
  } s2_t;

  typedef struct packed {
    cplx_t x;
    cplx_t y;
    logic  last;
  } s3_t;

  s1_t  s1;
  s2_t  s2;
  s3_t  s3;
  logic v1, v2, v3;
  logic ld1, ld2, ld3, ld4;

  logic [N-1:0] p_rr, p_ii, p_ri, p_ir;
  cplx_t        t_nxt;
  cplx_t        x_nxt;
  cplx_t        y_nxt;

  // Each stage moves when empty or when the next one moves.
  assign ld4       = out_ready;
  assign ld3       = ~v3 | ld4;
  assign ld2       = ~v2 | ld3;
  assign ld1       = ~v1 | ld2;
  assign in_ready  = ld1;
  assign out_valid = v3;

  multiplier #(.N(N), .Q(Q)) u_rr (
    .a(s1.b.re), .b(s1.w.re), .p(p_rr)
  );
  multiplier #(.N(N), .Q(Q)) u_ii (
    .a(s1.b.im), .b(s1.w.im), .p(p_ii)
  );
  multiplier #(.N(N), .Q(Q)) u_ri (
    .a(s1.b.re), .b(s1.w.im), .p(p_ri)
  );
  multiplier #(.N(N), .Q(Q)) u_ir (
    .a(s1.b.im), .b(s1.w.re), .p(p_ir)
  );

  // SCALE keeps the carry bit and drops the LSB.
  function automatic logic [N-1:0] fit(input logic [N:0] v);
    fit = (SCALE != 0) ? v[N:1] : v[N-1:0];
  endfunction

  function automatic logic [N:0] sx(input logic [N-1:0] v);
    sx = {v[N-1], v};
  endfunction

  always_comb begin
    t_nxt.re = p_rr - p_ii;
    t_nxt.im = p_ri + p_ir;
    x_nxt.re = fit(sx(s2.a.re) + sx(s2.t.re));
    x_nxt.im = fit(sx(s2.a.im) + sx(s2.t.im));
    y_nxt.re = fit(sx(s2.a.re) - sx(s2.t.re));
    y_nxt.im = fit(sx(s2.a.im) - sx(s2.t.im));
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      v1 <= 1'b0;
      v2 <= 1'b0;
      v3 <= 1'b0;
      s1 <= '0;
      s2 <= '0;
      s3 <= '0;
    end else begin
      if (ld1) begin
        v1 <= in_valid;
        if (in_valid) begin
          s1.a    <= '{re: a_re, im: a_im};
          s1.b    <= '{re: b_re, im: b_im};
          s1.w    <= '{re: w_re, im: w_im};
          s1.last <= in_last;
        end
      end
      if (ld2) begin
        v2 <= v1;
        if (v1) begin
          s2.a    <= s1.a;
          s2.t    <= t_nxt;
          s2.last <= s1.last;
        end
      end
      if (ld3) begin
        v3 <= v2;
        if (v2) begin
          s3.x    <= x_nxt;
          s3.y    <= y_nxt;
          s3.last <= s2.last;
        end
      end
    end
  end

  assign x_re     = s3.x.re;
  assign x_im     = s3.x.im;
  assign y_re     = s3.y.re;
  assign y_im     = s3.y.im;
  assign out_last = s3.last;
endmodule

// File: tb/tb_fft_butterfly_pipe.sv
// Bench for fft_butterfly_pipe: SCALE=0 and SCALE=1 instances, shared stimulus.
// Expected results are queued at input transfer and checked at output transfer.

module tb_fft_butterfly_pipe;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0;
  logic        in_last = 1'b0;
  logic        out_ready = 1'b1;
  logic [15:0] a_re = '0, a_im = '0;
  logic [15:0] b_re = '0, b_im = '0;
  logic [15:0] w_re = '0, w_im = '0;

  logic        in_ready0, out_valid0, out_last0;
  logic [15:0] x_re0, x_im0, y_re0, y_im0;
  logic        in_ready1, out_valid1, out_last1;
  logic [15:0] x_re1, x_im1, y_re1, y_im1;

  always #5 clk = ~clk;

  fft_butterfly_pipe #(.N(16), .Q(8), .SCALE(0)) dut0 (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready0), .in_last(in_last),
    .a_re(a_re), .a_im(a_im), .b_re(b_re), .b_im(b_im),
    .w_re(w_re), .w_im(w_im),
    .out_valid(out_valid0), .out_ready(out_ready), .out_last(out_last0),
    .x_re(x_re0), .x_im(x_im0), .y_re(y_re0), .y_im(y_im0)
  );

  fft_butterfly_pipe #(.N(16), .Q(8), .SCALE(1)) dut1 (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready1), .in_last(in_last),
    .a_re(a_re), .a_im(a_im), .b_re(b_re), .b_im(b_im),
    .w_re(w_re), .w_im(w_im),
    .out_valid(out_valid1), .out_ready(out_ready), .out_last(out_last1),
    .x_re(x_re1), .x_im(x_im1), .y_re(y_re1), .y_im(y_im1)
  );

  typedef struct {
    logic [15:0] x_re, x_im, y_re, y_im;
    logic [15:0] sx_re, sx_im, sy_re, sy_im;
    logic        last;
  } exp_t;

  exp_t q[$];
  int   checks = 0;
  int   errors = 0;

  task automatic chk(input string nm, input logic [15:0] act,
                     input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %h want %h", nm, act, exp);
    end
  endtask

  function automatic exp_t mk(
    input logic [15:0] xr, xi, yr, yi, sxr, sxi, syr, syi,
    input logic l);
    exp_t e;
    e.x_re = xr;  e.x_im = xi;  e.y_re = yr;  e.y_im = yi;
    e.sx_re = sxr; e.sx_im = sxi; e.sy_re = syr; e.sy_im = syi;
    e.last = l;
    return e;
  endfunction

  // Called at posedge+1; returns at posedge+1 after the accepting edge.
  task automatic drive(
    input logic [15:0] ar, ai, br, bi, wr, wi,
    input logic l, input exp_t e);
    int n;
    a_re = ar; a_im = ai; b_re = br; b_im = bi;
    w_re = wr; w_im = wi; in_last = l; in_valid = 1'b1;
    n = 0;
    forever begin
      @(negedge clk);
      if (in_ready0) break;
      n++;
      if (n > 200) begin
        checks++;
        errors++;
        $display("FAIL accept_timeout got 0 want 1");
        break;
      end
    end
    q.push_back(e);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (q.size() != 0 && n < 100) begin
      @(posedge clk);
      n++;
    end
    #1;
    chk("drain_left", 16'(q.size()), 16'd0);
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (!rst && out_valid0 && out_ready) begin
      if (q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_beat got x_re=%h want none", x_re0);
      end else begin
        e = q.pop_front();
        chk("x_re", x_re0, e.x_re);
        chk("x_im", x_im0, e.x_im);
        chk("y_re", y_re0, e.y_re);
        chk("y_im", y_im0, e.y_im);
        chk("s_valid", {15'd0, out_valid1}, 16'd1);
        chk("sx_re", x_re1, e.sx_re);
        chk("sx_im", x_im1, e.sx_im);
        chk("sy_re", y_re1, e.sy_re);
        chk("sy_im", y_im1, e.sy_im);
        chk("last", {15'd0, out_last0}, {15'd0, e.last});
        chk("s_last", {15'd0, out_last1}, {15'd0, e.last});
      end
    end
  end

  initial begin
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    chk("rst_out_valid", {15'd0, out_valid0}, 16'd0);
    chk("rst_in_ready", {15'd0, in_ready0}, 16'd1);
    chk("rst_x_re", x_re0, 16'd0);
    chk("rst_y_im", y_im0, 16'd0);
    chk("rst_last", {15'd0, out_last0}, 16'd0);
    chk("rst_sx_re", x_re1, 16'd0);

    // Latency: single beat, out_valid on the third edge.
    drive(16'h0100, 16'h0000, 16'h0080, 16'h0000, 16'h0100, 16'h0000, 1'b0,
          mk(16'h0180, 16'h0000, 16'h0080, 16'h0000,
             16'h00C0, 16'h0000, 16'h0040, 16'h0000, 1'b0));
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("latency_valid", {15'd0, out_valid0}, {15'd0, (i == 2)});
    end
    @(posedge clk);
    #1;

    // Back-to-back vectors.
    drive(16'h0000, 16'h0000, 16'h0080, 16'h0080, 16'h0000, 16'hFF00, 1'b0,
          mk(16'h0080, 16'hFF80, 16'hFF80, 16'h0080,
             16'h0040, 16'hFFC0, 16'hFFC0, 16'h0040, 1'b0));
    drive(16'h0000, 16'h0000, 16'h0001, 16'h0000, 16'h0080, 16'h0000, 1'b0,
          mk(16'h0000, 16'h0000, 16'h0000, 16'h0000,
             16'h0000, 16'h0000, 16'h0000, 16'h0000, 1'b0));
    drive(16'h0000, 16'h0000, 16'hFFFF, 16'h0000, 16'h0080, 16'h0000, 1'b0,
          mk(16'hFFFF, 16'h0000, 16'h0001, 16'h0000,
             16'hFFFF, 16'h0000, 16'h0000, 16'h0000, 1'b0));
    drive(16'h7F00, 16'h0000, 16'h0200, 16'h0000, 16'h0100, 16'h0000, 1'b0,
          mk(16'h8100, 16'h0000, 16'h7D00, 16'h0000,
             16'h4080, 16'h0000, 16'h3E80, 16'h0000, 1'b0));
    drive(16'h0000, 16'h0000, 16'h8000, 16'h0000, 16'h0100, 16'h0000, 1'b0,
          mk(16'h8000, 16'h0000, 16'h8000, 16'h0000,
             16'hC000, 16'h0000, 16'h4000, 16'h0000, 1'b0));
    drive(16'h0100, 16'h0200, 16'h0100, 16'h0100, 16'h0100, 16'h0100, 1'b0,
          mk(16'h0100, 16'h0400, 16'h0100, 16'h0000,
             16'h0080, 16'h0200, 16'h0080, 16'h0000, 1'b0));
    drive(16'h0100, 16'hFF00, 16'h0300, 16'hFE00, 16'h0080, 16'h0040, 1'b1,
          mk(16'h0300, 16'hFEC0, 16'hFF00, 16'hFF40,
             16'h0180, 16'hFF60, 16'hFF80, 16'hFFA0, 1'b1));
    drain();

    // Backpressure: fill three stages, hold, then release.
    out_ready = 1'b0;
    for (int k = 1; k <= 3; k++)
      drive(16'(k << 8), 16'(k), 16'h0, 16'h0, 16'h0, 16'h0, 1'b0,
            mk(16'(k << 8), 16'(k), 16'(k << 8), 16'(k),
               16'(k << 7), 16'(k >> 1), 16'(k << 7), 16'(k >> 1), 1'b0));
    a_re = 16'hDEAD; a_im = 16'hBEEF; in_last = 1'b1; in_valid = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("stall_in_ready", {15'd0, in_ready0}, 16'd0);
      chk("stall_valid", {15'd0, out_valid0}, 16'd1);
      chk("stall_x_re", x_re0, 16'h0100);
      chk("stall_last", {15'd0, out_last0}, 16'd0);
    end
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    out_ready = 1'b1;
    for (int k = 4; k <= 5; k++)
      drive(16'(k << 8), 16'(k), 16'h0, 16'h0, 16'h0, 16'h0, 1'(k == 5),
            mk(16'(k << 8), 16'(k), 16'(k << 8), 16'(k),
               16'(k << 7), 16'(k >> 1), 16'(k << 7), 16'(k >> 1),
               1'(k == 5)));
    drain();

    // Reset with three beats in flight.
    out_ready = 1'b0;
    for (int k = 1; k <= 3; k++)
      drive(16'h1234, 16'h0, 16'h0100, 16'h0, 16'h0100, 16'h0, 1'b1,
            mk(16'h0, 16'h0, 16'h0, 16'h0,
               16'h0, 16'h0, 16'h0, 16'h0, 1'b0));
    rst = 1'b1;
    q.delete();
    @(posedge clk);
    #1;
    rst = 1'b0;
    out_ready = 1'b1;
    chk("mid_rst_valid", {15'd0, out_valid0}, 16'd0);
    chk("mid_rst_in_ready", {15'd0, in_ready0}, 16'd1);
    chk("mid_rst_x_re", x_re0, 16'd0);
    chk("mid_rst_y_re", y_re0, 16'd0);
    chk("mid_rst_last", {15'd0, out_last0}, 16'd0);
    chk("mid_rst_sx_re", x_re1, 16'd0);
    repeat (8) @(posedge clk);
    #1;
    drive(16'h0100, 16'h0000, 16'h0080, 16'h0000, 16'h0100, 16'h0000, 1'b1,
          mk(16'h0180, 16'h0000, 16'h0080, 16'h0000,
             16'h00C0, 16'h0000, 16'h0040, 16'h0000, 1'b1));
    drain();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
